fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end of the single-cycle MIPS datapath. Holds the PC, requests instruction words from instruction memory over a req/ready handshake, and presents each word to the decoder and datapath.
- On handshake acceptance, uses the decoder's resolved Branch/BranchType/Jump controls, plus ALU zero and rs data, to select the next PC (sequential, beq/bne, j/jal, jr).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- imem_req_o  out  1  fetch request to instruction memory
- imem_addr_o  out  32  word-aligned fetch address, equals pc_o
- imem_ready_i  in  1  memory returns imem_data_i this cycle
- imem_data_i  in  32  instruction word
- instr_o  out  32  held instruction to decoder (op = [31:26], funct = [5:0])
- instr_valid_o  out  1  instr_o is valid
- instr_ready_i  in  1  datapath consumes instr_o this cycle; controls below are valid
- Branch_i  in  1  decoder Branch
- BranchType_i  in  2  00 = beq (taken if zero), 11 = bne (taken if !zero), 01/10 = never taken
- Jump_i  in  2  00 = j/jal target, 01 = sequential/branch path, 10 = jr, 11 = treated as 01
- zero_i  in  1  ALU zero flag
- rs_data_i  in  32  register rs value for jr
- pc_o  out  32  PC of the current instruction
- pc_plus4_o  out  32  pc_o + 4, used for the jal link value
- misalign_o  out  1  one-cycle pulse when a jr target has nonzero bits [1:0]
- retired_cnt_o  out  CNT_W  count of accepted instructions

Behaviour:
- Reset (rst_i low, asynchronous):
  - pc_o = RESET_PC; instr_o = 0; state = IDLE.
  - imem_req_o, instr_valid_o, misalign_o and retired_cnt_o = 0.
- FSM states:
  - IDLE: one cycle after reset release, then go to REQ.
  - REQ: imem_req_o = 1, imem_addr_o = pc_o held stable. When imem_ready_i = 1, capture imem_data_i into instr_o and go to HOLD. The response can come in the first REQ cycle, giving a minimum REQ-to-HOLD latency of 1 cycle.
  - HOLD: instr_valid_o = 1, instr_o and pc_o held stable. When instr_ready_i = 1, load the next PC, increment retired_cnt_o and go to REQ.
- imem_ready_i is ignored outside REQ. instr_ready_i is ignored outside HOLD.
- Next-PC selection, evaluated only on HOLD && instr_ready_i:
  - Jump_i = 00: {pc_plus4[31:28], instr_o[25:0], 2'b00}.
  - Jump_i = 10: {rs_data_i[31:2], 2'b00}; misalign_o = 1 in the next cycle if rs_data_i[1:0] != 0.
  - Otherwise, if Branch_i and the branch is taken: pc_plus4 + (sign-extend(instr_o[15:0]) << 2), 32-bit wrap.
  - Otherwise: pc_plus4.
- Arithmetic: all PC adds are modulo 2^32. PC 32'hFFFF_FFFC wraps to 0.
- retired_cnt_o wraps to 0 at its maximum value.
- Throughput: at best one instruction every 2 cycles (REQ with immediate ready, then HOLD with immediate accept).
- Reset asserted mid-REQ or mid-HOLD: everything is cleared immediately; the pending memory response is discarded.

Decomposition:
- Shared package `mips_ctrl_pkg` holds:
  - Jump encodings JMP_J = 2'b00, JMP_SEQ = 2'b01, JMP_JR = 2'b10.
  - Branch-type encodings BT_BEQ = 2'b00, BT_BNE = 2'b11.
  - FSM state encoding.
- These constants are shared with the decoder.
- One sub-module: `next_pc_sel`, purely combinational, which takes pc, instr, controls, zero and rs_data and returns next_pc and misalign. The FSM, registers and counter stay in `fetch_unit`.

Test Plan:
- Reset, memory ready after 2 cycles with data 32'h2008_0005 (addi), instr_ready_i = 1 -> imem_addr_o = 0; instr_valid_o rises in the cycle after ready; then the next request goes to address 4 and retired_cnt_o = 1.
- beq at pc 8 with imm 16'hFFFE, Branch_i = 1, BranchType_i = 00, zero_i = 1 -> next address = 8 + 4 - 8 = 4. With zero_i = 0 -> next address = 12.
- bne at pc 8 with imm 3, BranchType_i = 11, zero_i = 0 -> next address 24. With zero_i = 1 -> next address 12.
- j at pc 32'h1000_0010 with target field 26'h000_0040, Jump_i = 00 -> next address 32'h1000_0100.
- jr with rs_data_i = 32'h0000_0042, Jump_i = 10 -> next address 32'h0000_0040; misalign_o pulses for exactly 1 cycle.
- instr_ready_i held low for 5 cycles in HOLD, then rst_i pulsed low in REQ with imem_ready_i high -> instr_o stays stable while held; after reset, pc_o = RESET_PC, outputs are 0, and the discarded response is never presented.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - control encodings and fetch FSM states shared by fetch and decode
package mips_ctrl_pkg;

    localparam logic [1:0] JMP_J   = 2'b00;
    localparam logic [1:0] JMP_SEQ = 2'b01;
    localparam logic [1:0] JMP_JR  = 2'b10;

    localparam logic [1:0] BT_BEQ  = 2'b00;
    localparam logic [1:0] BT_BNE  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    // Branch immediate becomes a signed byte offset
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - combinational next-PC selection for sequential, branch, j/jal and jr
module next_pc_sel
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_low,
    input  logic        branch,
    input  logic [1:0]  branch_type,
    input  logic [1:0]  jump,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic taken;

    // Types 01/10 never take, so only the two explicit encodings are matched
    assign taken = branch &&
                   (((branch_type == BT_BEQ) && zero) ||
                    ((branch_type == BT_BNE) && !zero));

    always_comb begin
        next_pc  = pc_plus4;
        misalign = 1'b0;
        if (jump == JMP_J) begin
            next_pc = {pc_plus4[31:28], instr_low, 2'b00};
        end else if (jump == JMP_JR) begin
            next_pc  = {rs_data[31:2], 2'b00};
            misalign = (rs_data[1:0] != 2'b00);
        end else if (taken) begin
            next_pc = pc_plus4 + branch_offset(instr_low[15:0]);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, instruction-memory handshake FSM and retired counter
module fetch_unit
    import mips_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_ready_i,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      instr_o,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    input  logic             Branch_i,
    input  logic [1:0]       BranchType_i,
    input  logic [1:0]       Jump_i,
    input  logic             zero_i,
    input  logic [31:0]      rs_data_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_plus4_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] retired_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic             misalign_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      pc_plus4;
    logic [31:0]      next_pc;
    logic             next_misalign;
    logic             accept;

    assign pc_plus4 = pc_q + 32'd4;
    assign accept   = (state_q == ST_HOLD) && instr_ready_i;

    next_pc_sel u_next_pc_sel (
        .pc_plus4    (pc_plus4),
        .instr_low   (instr_q[25:0]),
        .branch      (Branch_i),
        .branch_type (BranchType_i),
        .jump        (Jump_i),
        .zero        (zero_i),
        .rs_data     (rs_data_i),
        .next_pc     (next_pc),
        .misalign    (next_misalign)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            // misalign is a single-cycle pulse following the accepting edge
            misalign_q <= 1'b0;
            case (state_q)
                ST_IDLE: state_q <= ST_REQ;
                ST_REQ: begin
                    if (imem_ready_i) begin
                        instr_q <= imem_data_i;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        pc_q       <= next_pc;
                        misalign_q <= next_misalign;
                        cnt_q      <= cnt_q + CNT_ONE;
                        state_q    <= ST_REQ;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_req_o    = (state_q == ST_REQ);
    assign imem_addr_o   = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = (state_q == ST_HOLD);
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4;
    assign misalign_o    = misalign_q;
    assign retired_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic [31:0] imem_data_i = 32'h0;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic        Branch_i = 1'b0;
    logic [1:0]  BranchType_i = 2'b01;
    logic [1:0]  Jump_i = 2'b01;
    logic        zero_i = 1'b0;
    logic [31:0] rs_data_i = 32'h0;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        misalign_o;
    logic [31:0] retired_cnt_o;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] exp_cnt = 32'd0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_data_i   (imem_data_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .Branch_i      (Branch_i),
        .BranchType_i  (BranchType_i),
        .Jump_i        (Jump_i),
        .zero_i        (zero_i),
        .rs_data_i     (rs_data_i),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .misalign_o    (misalign_o),
        .retired_cnt_o (retired_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic fetch(input logic [31:0] data, input string tag);
        imem_ready_i = 1'b1;
        imem_data_i  = data;
        step();
        imem_ready_i = 1'b0;
        check({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd1);
        check({tag, "_instr"}, instr_o, data);
    endtask

    task automatic accept(input logic [1:0] jump, input logic br, input logic [1:0] bt,
                          input logic z, input logic [31:0] rs, input logic [31:0] exp_addr,
                          input string tag);
        Jump_i = jump; Branch_i = br; BranchType_i = bt; zero_i = z; rs_data_i = rs;
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        Jump_i = 2'b01; Branch_i = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        check({tag, "_addr"}, imem_addr_o, exp_addr);
        check({tag, "_req"}, {31'b0, imem_req_o}, 32'd1);
        check({tag, "_cnt"}, retired_cnt_o, exp_cnt);
    endtask

    initial begin
        // reset state
        #2;
        check("rst_pc", pc_o, 32'h0);
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_cnt", retired_cnt_o, 32'd0);
        check("rst_mis", {31'b0, misalign_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        check("idle_req", {31'b0, imem_req_o}, 32'd0);
        step();
        check("req_on", {31'b0, imem_req_o}, 32'd1);
        check("req_addr0", imem_addr_o, 32'h0);

        // memory ready after two waiting cycles
        step();
        check("wait1_valid", {31'b0, instr_valid_o}, 32'd0);
        step();
        check("wait2_req", {31'b0, imem_req_o}, 32'd1);
        fetch(32'h2008_0005, "addi");
        check("hold_req", {31'b0, imem_req_o}, 32'd0);
        accept(2'b01, 1'b0, 2'b00, 1'b0, 32'h0, 32'h4, "seq4");
        check("seq4_valid", {31'b0, instr_valid_o}, 32'd0);

        // Jump 11 behaves as sequential
        fetch(32'h0000_0000, "nop4");
        accept(2'b11, 1'b0, 2'b00, 1'b0, 32'h0, 32'h8, "seq8");

        // beq taken backward, then not taken
        fetch(32'h1000_FFFE, "beq");
        accept(2'b01, 1'b1, 2'b00, 1'b1, 32'h0, 32'h4, "beq_t");
        fetch(32'h0000_0000, "nop4b");
        accept(2'b01, 1'b0, 2'b00, 1'b0, 32'h0, 32'h8, "seq8b");
        fetch(32'h1000_FFFE, "beq2");
        accept(2'b01, 1'b1, 2'b00, 1'b0, 32'h0, 32'hC, "beq_nt");

        // j back to 8, bne taken, j back, bne not taken
        fetch(32'h0800_0002, "j8");
        accept(2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 32'h8, "j8a");
        fetch(32'h1400_0003, "bne");
        accept(2'b01, 1'b1, 2'b11, 1'b0, 32'h0, 32'd24, "bne_t");
        fetch(32'h0800_0002, "j8b");
        accept(2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 32'h8, "j8c");
        fetch(32'h1400_0003, "bne2");
        accept(2'b01, 1'b1, 2'b11, 1'b1, 32'h0, 32'hC, "bne_nt");

        // aligned jr to the j test location, then j with region bits
        fetch(32'h0200_0008, "jr_al");
        accept(2'b10, 1'b0, 2'b00, 1'b0, 32'h1000_0010, 32'h1000_0010, "jr_al");
        check("jr_al_mis", {31'b0, misalign_o}, 32'd0);
        fetch(32'h0800_0040, "j");
        check("j_pc4", pc_plus4_o, 32'h1000_0014);
        accept(2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 32'h1000_0100, "j");

        // misaligned jr: one-cycle pulse
        fetch(32'h0200_0008, "jr_mis");
        accept(2'b10, 1'b0, 2'b00, 1'b0, 32'h0000_0042, 32'h0000_0040, "jr_mis");
        check("mis_pulse", {31'b0, misalign_o}, 32'd1);
        step();
        check("mis_clear", {31'b0, misalign_o}, 32'd0);

        // stall in HOLD; memory ready is ignored there
        fetch(32'hDEAD_BEEF, "stall");
        imem_ready_i = 1'b1;
        imem_data_i  = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_instr", instr_o, 32'hDEAD_BEEF);
            check("stall_valid", {31'b0, instr_valid_o}, 32'd1);
            check("stall_pc", pc_o, 32'h0000_0040);
        end
        imem_ready_i = 1'b0;
        accept(2'b01, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_0044, "seq44");

        // reset in REQ with a pending response
        imem_ready_i = 1'b1;
        imem_data_i  = 32'hCAFE_F00D;
        #1 rst_i = 1'b0;
        #1;
        check("mid_pc", pc_o, 32'h0);
        check("mid_req", {31'b0, imem_req_o}, 32'd0);
        check("mid_instr", instr_o, 32'h0);
        check("mid_cnt", retired_cnt_o, 32'd0);
        check("mid_valid", {31'b0, instr_valid_o}, 32'd0);
        step();
        check("in_rst_instr", instr_o, 32'h0);
        rst_i = 1'b1;
        imem_ready_i = 1'b0;
        step();
        check("post_req", {31'b0, imem_req_o}, 32'd1);
        check("post_addr", imem_addr_o, 32'h0);
        check("post_instr", instr_o, 32'h0);
        check("post_valid", {31'b0, instr_valid_o}, 32'd0);
        step();
        check("post_valid2", {31'b0, instr_valid_o}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
